// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall vectors,
// FSM states and reset/zero constants.
package pipe_stall_ctrl_pkg;

  // stall bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;

  localparam logic        RstEnable  = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EX_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  // Reload value for the flush window counter (the event cycle itself counts as one).
  function automatic logic [3:0] fcnt_init(input int flush_cycles);
    return 4'(flush_cycles - 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_counter.sv
// stall_down_counter: loadable down-counter holding the EX multi-cycle stall.
// Flags zero and last (count == 1) drive the controller's exit decision.
module stall_down_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // clr (exception abort) outranks a same-cycle load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable)        cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates ID and EX stalls, sequences
// exception/ERET flushes. Optional PIPE_STALL_PERF_EN adds a stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_start,
  input  logic [CNT_W-1:0] ex_cycles,
  input  logic             except_valid,
  input  logic             eret,
  input  logic [31:0]      epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             ex_done,
  output logic [31:0]      stall_cycles
);

  localparam logic [3:0] FCNT_INIT = fcnt_init(FLUSH_CYCLES);

  state_t      state, state_n;
  logic [3:0]  fcnt, fcnt_n;
  logic [31:0] pc_q, pc_n;
  logic        done_q, done_n;

  logic        cnt_clr, cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] pc_c;
  logic        ex_go;

  stall_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (ex_cycles - 1'b1),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  assign ex_go = ex_start && (ex_cycles != '0);

  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    pc_n     = pc_q;
    done_n   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    stall_c  = STALL_NONE;
    flush_c  = 1'b0;
    pc_c     = ZeroWord;

    if (except_valid) begin
      // Exception beats everything and aborts any in-flight EX countdown.
      flush_c = 1'b1;
      pc_c    = eret ? epc : EXC_VECTOR;
      pc_n    = pc_c;
      fcnt_n  = FCNT_INIT;
      cnt_clr = 1'b1;
      state_n = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ex_go) begin
            stall_c = STALL_EX;
            if (ex_cycles == CNT_W'(1)) begin
              done_n = 1'b1;
            end else begin
              cnt_load = 1'b1;
              state_n  = ST_EX_WAIT;
            end
          end else if (stallreq_id) begin
            stall_c = STALL_ID;
          end
        end
        ST_EX_WAIT: begin
          stall_c = STALL_EX;
          if (cnt_zero) begin
            state_n = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          flush_c = 1'b1;
          pc_c    = pc_q;
          fcnt_n  = fcnt - 4'd1;
          if (fcnt <= 4'd1) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state  <= ST_IDLE;
      fcnt   <= 4'd0;
      pc_q   <= ZeroWord;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      fcnt   <= fcnt_n;
      pc_q   <= pc_n;
      done_q <= done_n;
    end
  end

  // Combinational outputs are gated so they read zero for the whole reset window.
  assign stall   = rst ? STALL_NONE : stall_c;
  assign flush   = rst ? 1'b0 : flush_c;
  assign new_pc  = rst ? ZeroWord : pc_c;
  assign ex_done = done_q && !flush_c && !rst;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable)                        perf_q <= ZeroWord;
    else if (stall[0] && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = ZeroWord;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: driver pushes model expectations per
// cycle, a negedge monitor pops and compares against the DUT.
module tb_pipe_stall_ctrl;

  localparam logic [31:0] EXC = 32'h0000_0020;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        ex_start = 1'b0;
  logic [5:0]  ex_cycles = '0;
  logic        except_valid = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_done;
  logic [31:0] stall_cycles;

  pipe_stall_ctrl #(.EXC_VECTOR(EXC), .FLUSH_CYCLES(FC), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
    .ex_cycles(ex_cycles), .except_valid(except_valid), .eret(eret), .epc(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .ex_done(ex_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic [31:0] perf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: remaining-cycle bookkeeping, not an FSM.
  int          m_ex_left = 0;
  int          m_fl_left = 0;
  bit          m_done_pend = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_perf = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic id, input logic es, input logic [5:0] n,
                       input logic ev, input logic er, input logic [31:0] pc);
    exp_t e;
    bit   done_next;
    @(posedge clk); #1;
    rst = r; stallreq_id = id; ex_start = es; ex_cycles = n;
    except_valid = ev; eret = er; epc = pc;
    e = '{stall: 6'b0, flush: 1'b0, pc: 32'h0, done: 1'b0, perf: 32'h0};
    if (r) begin
      m_ex_left = 0; m_fl_left = 0; m_done_pend = 0; m_pc = '0; m_perf = '0;
    end else begin
`ifdef PIPE_STALL_PERF_EN
      e.perf = m_perf;
`endif
      done_next = 0;
      if (ev) begin
        e.flush = 1; e.pc = er ? pc : EXC; m_pc = e.pc;
        m_fl_left = FC - 1; m_ex_left = 0;
      end else if (m_fl_left > 0) begin
        e.flush = 1; e.pc = m_pc; m_fl_left--;
      end else if (m_ex_left > 0) begin
        e.stall = 6'b001111; m_ex_left--;
        if (m_ex_left == 0) done_next = 1;
      end else if (es && n != 0) begin
        e.stall = 6'b001111; m_ex_left = int'(n) - 1;
        if (m_ex_left == 0) done_next = 1;
      end else if (id) begin
        e.stall = 6'b000111;
      end
      e.done = m_done_pend && !e.flush;
      m_done_pend = done_next;
      if (e.stall[0] && m_perf != 32'hFFFF_FFFF) m_perf++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int k, input logic id);
    for (int i = 0; i < k; i++) drive(0, id, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",        {26'b0, stall}, {26'b0, e.stall});
      chk("flush",        {31'b0, flush}, {31'b0, e.flush});
      chk("new_pc",       new_pc, e.pc);
      chk("ex_done",      {31'b0, ex_done}, {31'b0, e.done});
      chk("stall_cycles", stall_cycles, e.perf);
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 6'd3, 0, 0, 0);       // outputs forced low during reset
    idle(2, 0);
    // Reset mid-EX_WAIT
    drive(0, 0, 1, 6'd10, 0, 0, 0);
    idle(3, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(14, 0);
    // ID hazard for 3 cycles
    idle(3, 1);
    idle(2, 0);
    // EX multi-cycle with ID held
    drive(0, 1, 1, 6'd5, 0, 0, 0);
    idle(8, 1);
    idle(2, 0);
    // N edge cases
    drive(0, 0, 1, 6'd1, 0, 0, 0);
    idle(3, 0);
    drive(0, 1, 1, 6'd0, 0, 0, 0);
    drive(0, 0, 1, 6'd0, 0, 0, 0);
    idle(3, 0);
    // Exception aborts EX
    drive(0, 0, 1, 6'd8, 0, 0, 0);
    idle(2, 0);
    drive(0, 1, 0, 0, 1, 0, 32'hDEAD_BEEF);
    idle(12, 0);
    // ERET and back-to-back exceptions
    drive(0, 0, 0, 0, 1, 1, 32'h0040_0100);
    drive(0, 0, 0, 0, 1, 1, 32'h0040_0200);
    drive(0, 1, 1, 6'd4, 0, 0, 0);
    idle(3, 1);
    // ex_done cycle collides with an exception: flush wins
    drive(0, 0, 1, 6'd2, 0, 0, 0);
    idle(1, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(3, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) == 0),
            6'($urandom_range(0, 12)),
            ($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)),
            $urandom());
    end
    idle(2, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
